// File: rtl/edsac_pkg.sv
// Shared constants for the EDSAC-style mercury tank store.
package edsac_pkg;

    // Default tank geometry: 16 words of 36 bits each.
    localparam int DEF_TANK_WORDS = 16;
    localparam int DEF_WORD_BITS  = 36;

    // Widths of the position counters reported by every tank.
    localparam int BIT_POS_W  = 6;
    localparam int WORD_POS_W = 4;

endpackage

// File: rtl/delay_line.sv
// Serial delay line of LEN one-bit stages. Stage 0 takes din at each edge and
// every stored bit moves one stage toward the tail.
module delay_line #(
    parameter int LEN = 576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic tail
);

    logic [LEN-1:0] stages;

    // Shift toward the tail every edge; a reset empties the whole line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[LEN-2:0], din};
        end
    end

    assign tail = stages[LEN-1];

endmodule

// File: rtl/memory_tank.sv
// One storage tank: an L-bit recirculating delay line with write/recirculate
// input selection, a gated serial output and the (word, bit) position counters
// that say which stored bit is currently at the tail.
module memory_tank
    import edsac_pkg::*;
#(
    parameter int TANK_WORDS = edsac_pkg::DEF_TANK_WORDS,
    parameter int WORD_BITS  = edsac_pkg::DEF_WORD_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_gate,
    input  logic                  recirc,
    input  logic                  out_gate,
    input  logic                  mib,
    output logic                  mob,
    output logic [BIT_POS_W-1:0]  bit_pos,
    output logic [WORD_POS_W-1:0] word_pos,
    output logic                  word_start
);

    localparam int LINE_LEN = TANK_WORDS * WORD_BITS;

    localparam logic [BIT_POS_W-1:0]  LAST_BIT  = BIT_POS_W'(WORD_BITS - 1);
    localparam logic [WORD_POS_W-1:0] LAST_WORD = WORD_POS_W'(TANK_WORDS - 1);

    logic tail;
    logic line_in;

    // Writing wins over recirculation; with neither, the slot is refilled with 0.
    always_comb begin
        line_in = 1'b0;
        if (in_gate) begin
            line_in = mib;
        end else if (recirc) begin
            line_in = tail;
        end
    end

    delay_line #(
        .LEN (LINE_LEN)
    ) u_line (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (line_in),
        .tail  (tail)
    );

    // Position counters advance every edge, independent of the gates. Their
    // period equals the line length, so a bit written at (w, b) returns to
    // the tail exactly when the counters show (w, b) again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_pos  <= '0;
            word_pos <= '0;
        end else if (bit_pos == LAST_BIT) begin
            bit_pos <= '0;
            if (word_pos == LAST_WORD) begin
                word_pos <= '0;
            end else begin
                word_pos <= word_pos + WORD_POS_W'(1);
            end
        end else begin
            bit_pos <= bit_pos + BIT_POS_W'(1);
        end
    end

    assign mob        = tail & out_gate;
    assign word_start = (bit_pos == '0);

endmodule

// File: tb/tb_memory_tank.sv
// Bench for memory_tank. The reference model treats the tank as an addressed
// array mem_m[word][bit]: the slot currently at the tail is found from the
// number of cycles since reset, it is read by mob and rewritten at the edge.
module tb_memory_tank;

    localparam int TW = 16;
    localparam int WB = 36;
    localparam int L  = TW * WB;

    logic       clk;
    logic       rst_n;
    logic       in_gate;
    logic       recirc;
    logic       out_gate;
    logic       mib;
    logic       mob;
    logic [5:0] bit_pos;
    logic [3:0] word_pos;
    logic       word_start;

    // scoreboard
    logic [0:0] exp_q[$];
    int         checks;
    int         errors;

    // reference model
    logic       mem_m [TW][WB];
    int         t_m;
    bit         model_valid;
    logic       last_mob;

    memory_tank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_gate    (in_gate),
        .recirc     (recirc),
        .out_gate   (out_gate),
        .mib        (mib),
        .mob        (mob),
        .bit_pos    (bit_pos),
        .word_pos   (word_pos),
        .word_start (word_start)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n    = 1'b0;
        in_gate  = 1'b0;
        recirc   = 1'b0;
        out_gate = 1'b0;
        mib      = 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t_m);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic drive_cycle(input logic r, input logic ig, input logic rc,
                               input logic og, input logic mi);
        int w;
        int b;
        logic [0:0] e;
        rst_n    = r;
        in_gate  = ig;
        recirc   = rc;
        out_gate = og;
        mib      = mi;
        w = t_m / WB;
        b = t_m % WB;
        if (model_valid) exp_q.push_back(og & mem_m[w][b]);
        @(negedge clk);
        last_mob = mob;
        if (model_valid) begin
            e = exp_q.pop_front();
            check("mob", mob, e);
            check("bit_pos", bit_pos, b);
            check("word_pos", word_pos, w);
            check("word_start", word_start, (b == 0));
        end
        if (!r) begin
            foreach (mem_m[i, j]) mem_m[i][j] = 1'b0;
            t_m = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (ig) mem_m[w][b] = mi;
            else if (!rc) mem_m[w][b] = 1'b0;
            t_m = (t_m + 1) % L;
        end
        @(posedge clk);
        #1;
    endtask

    // Two reset edges with the write path and output gate active.
    task automatic do_reset();
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic fill_ones();
        for (int n = 0; n < L; n++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [35:0] pat;
        int latency;
        bit seen;
        checks      = 0;
        errors      = 0;
        t_m         = 0;
        model_valid = 1'b0;
        last_mob    = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // keep the counters/line aligned for the next phase
        do_reset();

        // Single bit at word 3, bit 5; measure latency to first appearance
        seen    = 1'b0;
        latency = 0;
        for (int n = 0; n < 3 * L; n++) begin
            drive_cycle(1'b1, (n == 3 * WB + 5), 1'b1, 1'b1, 1'b1);
            if (!seen && n > 3 * WB + 5 && last_mob === 1'b1) begin
                seen    = 1'b1;
                latency = n - (3 * WB + 5) - 1;
            end
        end
        check("latency", latency, 575);

        // Word write of a pattern over word 7, then three circulations of readback
        do_reset();
        pat = 36'hA5A5A5A5A;
        for (int n = 0; n < L; n++)
            drive_cycle(1'b1, (n / WB == 7), 1'b1, 1'b0, pat[n % WB]);
        for (int n = 0; n < 3 * L; n++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Clear: all ones, one circulation without recirculation, then read
        fill_ones();
        for (int n = 0; n < L; n++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < L; n++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Priority: all ones, then write 0 over word 2 while recirc stays high
        fill_ones();
        for (int n = 0; n < L; n++)
            drive_cycle(1'b1, (n / WB == 2), 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < L; n++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Output masking over full content, across the word 15 -> 0 wrap
        fill_ones();
        for (int n = 0; n < L + 2; n++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < L; n++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic with occasional mid-stream resets
        for (int c = 0; c < 8; c++) begin
            int ig_pct;
            int rc_pct;
            ig_pct = $urandom_range(5, 60);
            rc_pct = $urandom_range(50, 100);
            for (int n = 0; n < L; n++) begin
                drive_cycle(($urandom_range(0, 1499) != 0),
                            ($urandom_range(0, 99) < ig_pct),
                            ($urandom_range(0, 99) < rc_pct),
                            ($urandom_range(0, 3) != 0),
                            $urandom_range(0, 1) == 1);
            end
        end
        for (int n = 0; n < L; n++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_tank.md
MEMORY_TANK -- requirements
Module: memory_tank

Interface
REQ-001 SHALL have parameter TANK_WORDS, default 16, number of words stored per tank.
REQ-002 SHALL have parameter WORD_BITS, default 36, bits per stored word; line length L = TANK_WORDS*WORD_BITS (576 by default).
REQ-003 SHALL have port clk  input  1  system clock; one serial bit position per rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_gate  input  1  write enable from tank decoder (tN_in); 1 = load mib into line.
REQ-006 SHALL have port recirc  input  1  from decoder tN_clr; 1 = recirculate tail bit, 0 = inhibit recirculation.
REQ-007 SHALL have port out_gate  input  1  read enable from decoder (rack up/down out); 1 = present tail bit on mob.
REQ-008 SHALL have port mib  input  1  serial memory input bus bit.
REQ-009 SHALL have port mob  output  1  serial memory output bus bit for this tank (feeds rack mob OR).
REQ-010 SHALL have port bit_pos  output  6  current bit index within word, 0..WORD_BITS-1.
REQ-011 SHALL have port word_pos  output  4  current word index within tank, 0..TANK_WORDS-1.
REQ-012 SHALL have port word_start  output  1  high while bit_pos == 0.

Function
REQ-013 SHALL hold an L-bit serial delay line: at each rising edge, every stage shifts one place toward the tail, and stage 0 loads the new input bit.
REQ-014 SHALL select the new input bit as: mib if in_gate = 1; else the tail bit if recirc = 1; else 0.
REQ-015 SHALL give in_gate priority over recirc when both are 1.
REQ-016 SHALL drive mob combinationally as tail bit AND out_gate; mob SHALL be 0 whenever out_gate = 0.
REQ-017 SHALL present a bit loaded at edge k on the tail, and hence on mob if out_gate = 1, during the cycle after edge k+L-1.
REQ-018 SHALL recirculate that bit into stage 0 at edge k+L, provided recirc = 1 and in_gate = 0 at that edge.
REQ-019 SHALL increment bit_pos every edge and wrap it from WORD_BITS-1 to 0.
REQ-020 SHALL increment word_pos exactly at the edge where bit_pos wraps, and wrap word_pos from TANK_WORDS-1 to 0.
REQ-021 SHALL keep the counters aligned with the line, so that the tail bit shown while (word_pos, bit_pos) = (w, b) is the bit that was loaded L cycles earlier at the same (w, b).
REQ-022 SHALL NOT let in_gate, recirc or out_gate affect the counters.
REQ-023 SHALL act on gate changes at the next edge only, with no internal latching of gate values.

Reset
REQ-024 SHALL clear all delay-line stages to 0 and set bit_pos = 0 and word_pos = 0 at any edge where rst_n = 0.
REQ-025 SHALL, after reset, drive mob = 0 and word_start = 1 in the first cycle.
REQ-026 SHALL discard all stored data when reset is applied mid-write or mid-read; writes resume aligned to position (0,0).

Structure
REQ-027 SHALL take the TANK_WORDS and WORD_BITS defaults and the counter widths from the shared package edsac_pkg.
REQ-028 SHALL implement storage as one instance of the existing delay_line sub-module of length L.
REQ-029 SHALL implement the input-select mux and the position counters in memory_tank itself.

Verification
REQ-030 SHALL verify reset: hold rst_n = 0 for 2 edges with mib = 1 and in_gate = 1 -> bit_pos = 0, word_pos = 0, word_start = 1, and mob = 0 with out_gate = 1.
REQ-031 SHALL verify a single-bit write: in_gate = 1 and mib = 1 for one edge at (3,5), then recirc = 1 and out_gate = 1 -> mob = 1 only at (3,5) in each subsequent circulation, with 575-cycle latency to the first appearance.
REQ-032 SHALL verify a word write: pattern 36'hA5A5A5A5A written over word 7, then 3 circulations with recirc = 1 -> mob serially reproduces the pattern in word 7 each time and is 0 in all other words.
REQ-033 SHALL verify clear: recirc = 0 and in_gate = 0 for one full circulation after writing all ones -> mob = 0 for the whole next circulation.
REQ-034 SHALL verify priority: in_gate = 1, recirc = 1, mib = 0 over word 2, which holds all ones -> word 2 reads 0 next circulation while other words are retained.
REQ-035 SHALL verify counter wrap and out_gate masking: word_pos 15->0 occurs on the same edge as bit_pos 35->0, and out_gate = 0 forces mob = 0 regardless of content.
